// File: rtl/unary_ctrl_pkg.sv
// Shared definitions for the unary-rate border multiplier controller.
//   - ctrl_state_t : controller FSM state encoding
//   - DATA_WIDTH   : default operand/count precision
//   - MAX_LEN_LOG2 : largest run-length exponent at the default precision
//   - MIN_LEN_LOG2 : smallest run-length exponent (L = 2 cycles)
package unary_ctrl_pkg;

    localparam int DATA_WIDTH   = 16;
    localparam int MAX_LEN_LOG2 = DATA_WIDTH - 1;
    localparam int MIN_LEN_LOG2 = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLR  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } ctrl_state_t;

endpackage

// File: rtl/unary_mul_ctrl_bit_counter.sv
// Counts the 1s seen on a bitstream.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear (has priority over counting)
//   en       : counting window
//   inc      : bit to accumulate while en is high
//   count    : running count
module bit_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && inc) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/unary_mul_ctrl.sv
// Sequencer for one unary-rate border multiplier and its two Sobol
// generators: accepts an operand pair, clears the generators, runs the
// datapath for 2^n cycles while counting the product and input bitstreams,
// then offers the counts as a result with backpressure.
//   clk, rst               : clock, asynchronous active-high reset
//   cfg_len_log2           : run-length exponent, sampled at accept
//   in_valid/in_ready      : operand handshake
//   in_data_i/in_data_w    : operands
//   pe_data_i/pe_data_w    : operands latched at accept, to the datapath
//   pe_clr                 : synchronous clear to the Sobol generators
//   pe_en                  : datapath enable / counting window
//   pe_o_bit/pe_i_bit      : product and input-stream bits from the datapath
//   out_valid/out_ready    : result handshake
//   out_prod/out_icnt      : 1s counted on pe_o_bit / pe_i_bit
//   busy                   : controller not idle
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready high
// CLR   | one cycle clearing generators and all counters
// RUN   | L = 2^n cycles with pe_en high, counting bitstreams
// DONE  | result presented until out_ready
module unary_mul_ctrl
    import unary_ctrl_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LEN_W-1:0] cfg_len_log2,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-2:0] in_data_i,
    input  logic [WIDTH-2:0] in_data_w,
    output logic [WIDTH-2:0] pe_data_i,
    output logic [WIDTH-2:0] pe_data_w,
    output logic             pe_clr,
    output logic             pe_en,
    input  logic             pe_o_bit,
    input  logic             pe_i_bit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_prod,
    output logic [WIDTH-1:0] out_icnt,
    output logic             busy
);

    // Largest exponent whose run length still fits the WIDTH-bit counts.
    localparam int N_MAX = WIDTH - 1;

    ctrl_state_t      state, state_nxt;
    logic [LEN_W-1:0] len_log2_q;
    logic [LEN_W-1:0] len_log2_clamped;
    logic [WIDTH-1:0] cyc_cnt;
    logic [WIDTH-1:0] last_cyc;
    logic             accept;
    logic             run_last;

    assign accept = in_valid && in_ready;

    always_comb begin
        len_log2_clamped = cfg_len_log2;
        if (int'(cfg_len_log2) < MIN_LEN_LOG2) begin
            len_log2_clamped = LEN_W'(MIN_LEN_LOG2);
        end else if (int'(cfg_len_log2) > N_MAX) begin
            len_log2_clamped = LEN_W'(N_MAX);
        end
    end

    // cyc_cnt runs 0 .. L-1 during RUN; the last RUN cycle is at L-1.
    assign last_cyc = (WIDTH'(1) << len_log2_q) - WIDTH'(1);
    assign run_last = (cyc_cnt == last_cyc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        pe_clr    = 1'b0;
        pe_en     = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    state_nxt = CLR;
                end
            end
            CLR: begin
                pe_clr    = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                pe_en = 1'b1;
                if (run_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operands and run length are captured only at accept, so input
    // activity during a run cannot disturb it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pe_data_i  <= '0;
            pe_data_w  <= '0;
            len_log2_q <= '0;
        end else if (accept) begin
            pe_data_i  <= in_data_i;
            pe_data_w  <= in_data_w;
            len_log2_q <= len_log2_clamped;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_cnt <= '0;
        end else if (pe_clr) begin
            cyc_cnt <= '0;
        end else if (pe_en) begin
            cyc_cnt <= cyc_cnt + WIDTH'(1);
        end
    end

    bit_counter #(.WIDTH(WIDTH)) u_prod_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (pe_clr),
        .en    (pe_en),
        .inc   (pe_o_bit),
        .count (out_prod)
    );

    bit_counter #(.WIDTH(WIDTH)) u_icnt_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (pe_clr),
        .en    (pe_en),
        .inc   (pe_i_bit),
        .count (out_icnt)
    );

endmodule

// File: tb/tb_unary_mul_ctrl.sv
module tb_unary_mul_ctrl;

    localparam int WIDTH = 16;
    localparam int LEN_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [LEN_W-1:0] cfg_len_log2 = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-2:0] in_data_i = '0;
    logic [WIDTH-2:0] in_data_w = '0;
    logic [WIDTH-2:0] pe_data_i;
    logic [WIDTH-2:0] pe_data_w;
    logic             pe_clr;
    logic             pe_en;
    logic             pe_o_bit = 1'b0;
    logic             pe_i_bit = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_prod;
    logic [WIDTH-1:0] out_icnt;
    logic             busy;

    int tests = 0;
    int fails = 0;

    unary_mul_ctrl #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_len_log2 (cfg_len_log2),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data_i    (in_data_i),
        .in_data_w    (in_data_w),
        .pe_data_i    (pe_data_i),
        .pe_data_w    (pe_data_w),
        .pe_clr       (pe_clr),
        .pe_en        (pe_en),
        .pe_o_bit     (pe_o_bit),
        .pe_i_bit     (pe_i_bit),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_prod     (out_prod),
        .out_icnt     (out_icnt),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Run length from the rules: exponent clamped to [1, WIDTH-1], L = 2^n.
    function automatic int run_len(input int n);
        int e;
        e = n;
        if (e < 1) e = 1;
        if (e > WIDTH - 1) e = WIDTH - 1;
        return 1 << e;
    endfunction

    // One transaction. Cycle c counts from the accept edge: c=1 is the clear
    // cycle, c=2..L+1 are run cycles, c=L+2 presents the result.
    // mode 0: random bits, 1: both bits held at 1, 2: product alternates
    // 1,0 from the first run cycle with input bit 0.
    task automatic run_op(input logic [WIDTH-2:0] di, input logic [WIDTH-2:0] dw,
                          input logic [LEN_W-1:0] n, input int mode, input int hold,
                          input string name);
        int         len, waited, exp_p, exp_i;
        logic       ob, ib;
        logic [4:0] ctrl, ctrl_exp;
        len = run_len(int'(n));
        exp_p = 0;
        exp_i = 0;
        waited = 0;
        while (in_ready !== 1'b1 && waited < 50) begin
            step();
            waited++;
        end
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s_ready_wait: in_ready=%b required 1", name, in_ready);
        end
        in_valid     = 1'b1;
        in_data_i    = di;
        in_data_w    = dw;
        cfg_len_log2 = n;
        step();
        in_valid = 1'($urandom);
        for (int c = 1; c <= len + 1; c++) begin
            ctrl     = {pe_clr, pe_en, out_valid, busy, in_ready};
            ctrl_exp = (c == 1) ? 5'b10010 : 5'b01010;
            tests++;
            if (ctrl !== ctrl_exp) begin
                fails++;
                $display("FAIL %s_ctrl c=%0d: {clr,en,ov,busy,ir}=%b required %b", name, c, ctrl, ctrl_exp);
            end
            tests++;
            if (pe_data_i !== di || pe_data_w !== dw) begin
                fails++;
                $display("FAIL %s_pe_data c=%0d: %h/%h required %h/%h", name, c, pe_data_i, pe_data_w, di, dw);
            end
            in_data_i    = (WIDTH-1)'($urandom);
            in_data_w    = (WIDTH-1)'($urandom);
            cfg_len_log2 = LEN_W'($urandom);
            in_valid     = 1'($urandom);
            case (mode)
                1:       begin ob = 1'b1; ib = 1'b1; end
                2:       begin ob = (c >= 2) ? ((c - 2) % 2 == 0) : 1'($urandom); ib = (c >= 2) ? 1'b0 : 1'($urandom); end
                default: begin ob = 1'($urandom); ib = 1'($urandom); end
            endcase
            if (c >= 2) begin
                exp_p += int'(ob);
                exp_i += int'(ib);
            end
            pe_o_bit = ob;
            pe_i_bit = ib;
            step();
        end
        in_valid = 1'b1;
        for (int h = 0; h <= hold; h++) begin
            ctrl = {pe_clr, pe_en, out_valid, busy, in_ready};
            tests++;
            if (ctrl !== 5'b00110) begin
                fails++;
                $display("FAIL %s_done h=%0d: {clr,en,ov,busy,ir}=%b required 00110", name, h, ctrl);
            end
            tests++;
            if (out_prod !== WIDTH'(exp_p) || out_icnt !== WIDTH'(exp_i)) begin
                fails++;
                $display("FAIL %s_counts h=%0d: prod=%0d icnt=%0d required %0d %0d", name, h, out_prod, out_icnt, exp_p, exp_i);
            end
            tests++;
            if (pe_data_i !== di || pe_data_w !== dw) begin
                fails++;
                $display("FAIL %s_pe_data_done h=%0d: %h/%h required %h/%h", name, h, pe_data_i, pe_data_w, di, dw);
            end
            pe_o_bit  = 1'($urandom);
            pe_i_bit  = 1'($urandom);
            out_ready = (h == hold);
            step();
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        ctrl = {pe_clr, pe_en, out_valid, busy, in_ready};
        tests++;
        if (ctrl !== 5'b00001) begin
            fails++;
            $display("FAIL %s_idle: {clr,en,ov,busy,ir}=%b required 00001", name, ctrl);
        end
    endtask

    task automatic test_reset();
        #3;
        tests++;
        if ({pe_clr, pe_en, out_valid, busy} !== 4'b0000 || out_prod !== '0 || out_icnt !== '0 ||
            pe_data_i !== '0 || pe_data_w !== '0) begin
            fails++;
            $display("FAIL reset_outputs: clr=%b en=%b ov=%b busy=%b prod=%h icnt=%h di=%h dw=%h required all 0",
                     pe_clr, pe_en, out_valid, busy, out_prod, out_icnt, pe_data_i, pe_data_w);
        end
        @(negedge clk);
        rst = 1'b0;
        step();
        tests++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: in_ready=%b busy=%b required 1 0", in_ready, busy);
        end
    endtask

    task automatic test_ones();
        run_op(15'h1234, 15'h4321, 4'd4, 1, 0, "ones_n4");
    endtask

    task automatic test_alternating();
        run_op(15'h7fff, 15'h0001, 4'd3, 2, 0, "alt_n3");
    endtask

    task automatic test_clamp_low();
        run_op(15'h0aaa, 15'h5555, 4'd0, 0, 0, "clamp_n0");
    endtask

    task automatic test_backpressure();
        run_op((WIDTH-1)'($urandom), (WIDTH-1)'($urandom), 4'd5, 0, 5, "hold5");
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 6; k++) begin
            run_op((WIDTH-1)'($urandom), (WIDTH-1)'($urandom),
                   LEN_W'($urandom_range(0, 6)), 0, $urandom_range(0, 3), "b2b");
        end
    endtask

    task automatic test_clamp_high();
        run_op(15'h0f0f, 15'h7070, 4'd15, 1, 0, "clamp_n15");
    endtask

    task automatic test_reset_mid_run();
        in_valid     = 1'b1;
        in_data_i    = 15'h2468;
        in_data_w    = 15'h1357;
        cfg_len_log2 = 4'd4;
        pe_o_bit     = 1'b1;
        pe_i_bit     = 1'b1;
        step();
        in_valid = 1'b0;
        for (int c = 1; c < 8; c++) step();
        #1;
        rst = 1'b1;
        #1;
        tests++;
        if ({pe_clr, pe_en, out_valid, busy} !== 4'b0000 || out_prod !== '0 || out_icnt !== '0 ||
            pe_data_i !== '0 || pe_data_w !== '0) begin
            fails++;
            $display("FAIL midrun_reset: clr=%b en=%b ov=%b busy=%b prod=%h icnt=%h di=%h dw=%h required all 0",
                     pe_clr, pe_en, out_valid, busy, out_prod, out_icnt, pe_data_i, pe_data_w);
        end
        step();
        rst = 1'b0;
        step();
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL midrun_release: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        end
        run_op(15'h0101, 15'h1010, 4'd4, 1, 0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_ones();
        test_alternating();
        test_clamp_low();
        test_backpressure();
        test_back_to_back();
        test_clamp_high();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/unary_mul_ctrl.md
# unary_mul_ctrl

Sequencer for one unary-rate border multiplier and its two Sobol generators. Accepts an operand pair over a valid/ready handshake, clears the generators, enables the datapath for a configurable power-of-two number of cycles, counts the product and input bitstreams, then presents the counts as a result with valid/ready backpressure. It sits between the array's operand feeder and the border PE, one controller per border PE.

## Interface
- WIDTH, 16, operand precision; operands are WIDTH-1 bits, counts are WIDTH bits
- LEN_W, 4, width of the run-length configuration field
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-high reset
- cfg_len_log2  in  LEN_W  run length exponent; run lasts L = 2^n cycles; sampled only at input accept
- in_valid  in  1  operand pair available
- in_ready  out  1  controller can accept an operand pair
- in_data_i  in  WIDTH-1  input operand
- in_data_w  in  WIDTH-1  weight operand
- pe_data_i  out  WIDTH-1  latched input operand to the datapath
- pe_data_w  out  WIDTH-1  latched weight operand to the datapath
- pe_clr  out  1  synchronous clear to both Sobol generators
- pe_en  out  1  generator/datapath enable; counting window
- pe_o_bit  in  1  product bit from the datapath
- pe_i_bit  in  1  input-stream bit from the datapath
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts the result
- out_prod  out  WIDTH  number of 1s on pe_o_bit during the run
- out_icnt  out  WIDTH  number of 1s on pe_i_bit during the run
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, CLR, RUN, DONE.
- IDLE: in_ready=1. On in_valid&in_ready: latch in_data_i/in_data_w into pe_data_*, latch clamped n, go to CLR.
- Clamp: n=0 becomes 1; n>WIDTH-1 becomes WIDTH-1. Therefore 2 ≤ L ≤ 2^(WIDTH-1).
- CLR (exactly 1 cycle): pe_clr=1, pe_en=0, both counters and the cycle counter cleared. Go to RUN.
- RUN (exactly L cycles): pe_en=1. Each cycle out_prod += pe_o_bit and out_icnt += pe_i_bit. After the L-th cycle, go to DONE.
- DONE: out_valid=1 and counts held stable. On out_ready, go to IDLE.
- Count width: maximum count is L = 2^(WIDTH-1), which fits in WIDTH bits. No saturation logic is needed. The cycle counter is WIDTH bits.
- pe_data_* are stable from the accept edge until the next accept. Input changes outside IDLE are ignored.
- Reset, at any time including mid-RUN or mid-DONE: state=IDLE, all counters=0, pe_data_*=0, pe_clr=0, pe_en=0, out_valid=0, busy=0, in_ready=1 (in_ready comes up once rst deasserts). An interrupted run produces no result.

## Timing
- Accept handshake at edge t. CLR occupies cycle t+1. RUN occupies cycles t+2 … t+1+L. out_valid rises in cycle t+2+L.
- Latency from accept to out_valid is L+2 cycles. Minimum accept-to-accept spacing is L+3 cycles: DONE→IDLE costs one bubble cycle.
- pe_o_bit and pe_i_bit are sampled on the edge ending each RUN cycle, i.e. in the same cycle that pe_en is high.
- out_valid stays asserted and out_prod/out_icnt stay unchanged until out_ready is sampled high. out_ready while not in DONE has no effect.
- in_ready is 0 whenever busy=1. There is no combinational path from in_valid to in_ready or from out_ready to out_valid.

## Structure
- Package unary_ctrl_pkg holds:
  - the state enum (IDLE, CLR, RUN, DONE)
  - MAX_LEN_LOG2 = WIDTH-1
  - MIN_LEN_LOG2 = 1
- Sub-module bit_counter holds a WIDTH-bit counter with synchronous clear, enable and increment-by-bit inputs. It is instantiated twice, once for out_prod and once for out_icnt.
- The cycle counter and the FSM live in the top module.

## Test plan
- WIDTH=16, n=4, pe_o_bit=1 and pe_i_bit=1 held constant → out_valid rises exactly 18 cycles after accept, out_prod=16, out_icnt=16, pe_en high for exactly 16 cycles, pe_clr high for exactly 1 cycle.
- n=3, pe_o_bit alternating 1,0 starting in the first RUN cycle, pe_i_bit=0 → out_prod=4, out_icnt=0.
- n=0 → clamps to L=2, out_valid at accept+4. n=15 with pe_o_bit=1 → clamps to L=32768, out_prod=0x8000.
- Hold out_ready=0 for 5 cycles after out_valid, with in_valid=1 throughout → out_valid and counts stay stable, in_ready=0, no new accept. When out_ready=1: next cycle IDLE, accept one cycle later.
- Assert rst for 1 cycle at RUN cycle 7 of 16 → all outputs at their reset values immediately. After release, a fresh run with n=4 and pe_o_bit=1 yields out_prod=16.
- Change in_data_i, in_data_w and cfg_len_log2 during RUN → pe_data_* and the run length are unchanged from the values latched at accept.
